// File: rtl/slow_mem_pkg.sv
// Shared constants for the multi-channel slow memory model: FSM state codes and
// the helper that sizes the latency counter.
package slow_mem_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, returning
// the grant both one-hot and as an index.
module rr_arbiter #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [NCH-1:0]   req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NCH-1:0]   grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             valid
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        // Outer loop walks priority order; the first hit blocks all later ones.
        for (int i = 0; i < int'(NCH); i++) begin
            for (int j = 0; j < int'(NCH); j++) begin
                if (!valid && req[j] && ((int'(ptr) + i) % int'(NCH)) == j) begin
                    valid     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = PTR_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/slow_memory_mc.sv
// Multi-channel fixed-latency line memory behind a round-robin arbiter.
// Define SLOW_MEM_STATS_EN to build the saturating access/busy statistics counters.
module slow_memory_mc
    import slow_mem_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          mem_read,
    input  logic [NCH-1:0]          mem_write,
    input  logic [NCH*ADDR_W-1:0]   mem_addr,
    input  logic [NCH*LINE_W-1:0]   mem_wdata,
    output logic [NCH*LINE_W-1:0]   mem_rdata,
    output logic [NCH-1:0]          mem_ready,
    output logic                    busy,
    output logic [CNT_W-1:0]        stat_busy_cycles,
    output logic [NCH*CNT_W-1:0]    stat_access
);

    localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LAT_W = cnt_width(LATENCY);
    localparam logic [LAT_W-1:0] LAST = LAT_W'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  gnt_q, gnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] rdata_q [NCH];
    logic [LINE_W-1:0] mem [DEPTH];

    logic [NCH-1:0]    req;
    logic [NCH-1:0]    arb_grant;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_valid;
    logic              commit;
    logic              addr_unused;

    assign req = mem_read | mem_write;
    // Address bits above the array index alias onto the same line.
    assign addr_unused = ^mem_addr;

    rr_arbiter #(
        .NCH   (NCH),
        .PTR_W (PTR_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    assign commit = (state_q == StWait) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StWait;
                    gnt_d   = arb_idx;
                    // Read and write together on the granted channel is a write.
                    wr_d    = |(arb_grant & mem_write);
                    cnt_d   = '0;
                    idx_d   = '0;
                    wdata_d = '0;
                    for (int k = 0; k < int'(NCH); k++) begin
                        if (arb_grant[k]) begin
                            idx_d   = mem_addr[k*ADDR_W +: IDX_W];
                            wdata_d = mem_wdata[k*LINE_W +: LINE_W];
                        end
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                ptr_d   = (int'(gnt_q) == int'(NCH) - 1) ? '0 : gnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < int'(NCH); k++) begin
                rdata_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < int'(NCH); k++) begin
                if (commit && !wr_q && int'(gnt_q) == k) begin
                    rdata_q[k] <= mem[idx_q];
                end
            end
        end
    end

    // Array is not reset; a commit coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_comb begin
        mem_ready = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            mem_ready[k] = (state_q == StDone) && (int'(gnt_q) == k);
        end
    end

    assign busy = (state_q != StIdle);

    for (genvar k = 0; k < int'(NCH); k++) begin : g_rdata
        assign mem_rdata[k*LINE_W +: LINE_W] = rdata_q[k];
    end

`ifdef SLOW_MEM_STATS_EN
    logic [CNT_W-1:0] busy_cnt_q;
    logic [CNT_W-1:0] acc_q [NCH];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_q <= '0;
            for (int k = 0; k < int'(NCH); k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            if (|req && !(&busy_cnt_q)) begin
                busy_cnt_q <= busy_cnt_q + 1'b1;
            end
            for (int k = 0; k < int'(NCH); k++) begin
                if (mem_ready[k] && !(&acc_q[k])) begin
                    acc_q[k] <= acc_q[k] + 1'b1;
                end
            end
        end
    end

    assign stat_busy_cycles = busy_cnt_q;
    for (genvar k = 0; k < int'(NCH); k++) begin : g_stat
        assign stat_access[k*CNT_W +: CNT_W] = acc_q[k];
    end
`else
    assign stat_busy_cycles = '0;
    assign stat_access      = '0;
`endif

endmodule

// File: tb/tb_slow_memory_mc.sv
// Self-checking bench for slow_memory_mc against a transaction-level model
// (line array, per-channel read registers, completion counts, timing rules).
module tb_slow_memory_mc;

    localparam int NCH     = 2;
    localparam int LINE_W  = 128;
    localparam int ADDR_W  = 28;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 8;
    localparam int CNT_W   = 32;
    localparam int TURN    = LATENCY + 1;
`ifdef SLOW_MEM_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NCH-1:0]        mem_read = '0;
    logic [NCH-1:0]        mem_write = '0;
    logic [NCH*ADDR_W-1:0] mem_addr = '0;
    logic [NCH*LINE_W-1:0] mem_wdata = '0;
    logic [NCH*LINE_W-1:0] mem_rdata;
    logic [NCH-1:0]        mem_ready;
    logic                  busy;
    logic [CNT_W-1:0]      stat_busy_cycles;
    logic [NCH*CNT_W-1:0]  stat_access;

    int errors = 0;
    int checks = 0;

    logic [LINE_W-1:0] model_mem [int];
    logic [LINE_W-1:0] model_rdata [NCH];
    int unsigned       model_access [NCH];
    int unsigned       model_busy;

    slow_memory_mc #(
        .NCH     (NCH),
        .LINE_W  (LINE_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready),
        .busy             (busy),
        .stat_busy_cycles (stat_busy_cycles),
        .stat_access      (stat_access)
    );

    always #5 clk = ~clk;

    // Cycles in which any request is visible at the clock edge.
    always @(posedge clk) begin
        if (rst) model_busy <= 0;
        else if (|(mem_read | mem_write)) model_busy <= model_busy + 1;
    end

    function automatic logic [CNT_W-1:0] exp_stat(input int unsigned v);
        return CNT_W'(v) & {CNT_W{STATS_ON}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input bit rd, input bit wr,
                           input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        mem_read[ch]                    = rd;
        mem_write[ch]                   = wr;
        mem_addr[ch*ADDR_W +: ADDR_W]   = a;
        mem_wdata[ch*LINE_W +: LINE_W]  = d;
    endtask

    task automatic model_complete(input int ch, input bit wr, input logic [ADDR_W-1:0] a,
                                  input logic [LINE_W-1:0] d);
        int idx;
        idx = int'(a) % DEPTH;
        if (wr) model_mem[idx] = d;
        else model_rdata[ch] = model_mem.exists(idx) ? model_mem[idx] : 'x;
        model_access[ch]++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        mem_read = '0;
        mem_write = '0;
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            model_rdata[k] = '0;
            model_access[k] = 0;
        end
    endtask

    // Wait for mem_ready[ch]; cycles=-1 on timeout, other=1 if another channel pulsed.
    task automatic wait_ready(input int ch, output int cycles, output bit other);
        cycles = 0;
        other = 1'b0;
        while (cycles < 40) begin
            tick();
            cycles++;
            for (int k = 0; k < NCH; k++) if (k != ch && mem_ready[k]) other = 1'b1;
            if (mem_ready[ch]) return;
        end
        cycles = -1;
    endtask

    // Issue from IDLE, wait for completion, drop the request, step back to IDLE.
    task automatic run_txn(input int ch, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [LINE_W-1:0] d, output int cycles, output bit other);
        set_req(ch, rd, wr, a, d);
        wait_ready(ch, cycles, other);
        mem_read[ch] = 1'b0;
        mem_write[ch] = 1'b0;
        if (cycles > 0) model_complete(ch, wr, a, d);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (mem_ready !== '0) begin errors++;
            $display("FAIL reset_ready: got %b want 0", mem_ready); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_rdata !== '0) begin errors++;
            $display("FAIL reset_rdata: got %h want 0", mem_rdata); end
        checks++; if (stat_busy_cycles !== '0 || stat_access !== '0) begin errors++;
            $display("FAIL reset_stats: got %0d/%h want 0", stat_busy_cycles, stat_access); end
    endtask

    task automatic test_single_read();
        int cyc;
        bit oth;
        bit busy_ok;
        logic [LINE_W-1:0] pat;
        pat = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
        run_txn(0, 1'b0, 1'b1, 28'd5, pat, cyc, oth);
        tick();
        checks++; if (cyc !== TURN) begin errors++;
            $display("FAIL preload_latency: got %0d want %0d", cyc, TURN); end
        set_req(0, 1'b1, 1'b0, 28'd5, '0);
        busy_ok = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (!mem_ready[0] && busy !== 1'b1) busy_ok = 1'b0;
            if (mem_ready[0]) break;
        end
        mem_read[0] = 1'b0;
        if (cyc >= 40) cyc = -1;
        else model_complete(0, 1'b0, 28'd5, '0);
        checks++; if (cyc !== TURN) begin errors++;
            $display("FAIL read_latency: got %0d want %0d", cyc, TURN); end
        checks++; if (mem_rdata[0 +: LINE_W] !== pat) begin errors++;
            $display("FAIL read_data: got %h want %h", mem_rdata[0 +: LINE_W], pat); end
        checks++; if (!busy_ok || busy !== 1'b1) begin errors++;
            $display("FAIL read_busy: got %b want 1", busy); end
        tick();
        checks++; if (mem_ready !== '0 || busy !== 1'b0) begin errors++;
            $display("FAIL ready_width: got %b/%b want 0/0", mem_ready, busy); end
    endtask

    task automatic test_write_read();
        int cyc;
        bit oth;
        logic [LINE_W-1:0] ch1_before;
        ch1_before = model_rdata[1];
        run_txn(1, 1'b0, 1'b1, 28'd7, 128'h1234, cyc, oth);
        tick();
        checks++; if (mem_rdata[LINE_W +: LINE_W] !== ch1_before) begin errors++;
            $display("FAIL write_keeps_rdata: got %h want %h", mem_rdata[LINE_W +: LINE_W],
                     ch1_before); end
        run_txn(0, 1'b1, 1'b0, 28'd7, '0, cyc, oth);
        checks++; if (cyc !== TURN || mem_rdata[0 +: LINE_W] !== 128'h1234) begin errors++;
            $display("FAIL raw_data: got %h (lat %0d) want 1234 (lat %0d)",
                     mem_rdata[0 +: LINE_W], cyc, TURN); end
        checks++; if (oth) begin errors++;
            $display("FAIL raw_other_ready: got 1 want 0"); end
        tick();
    endtask

    task automatic test_contention();
        int c;
        int r0;
        int r1;
        bit overlap;
        apply_reset();
        set_req(0, 1'b1, 1'b0, 28'd5, '0);
        set_req(1, 1'b1, 1'b0, 28'd7, '0);
        c = 0; r0 = -1; r1 = -1; overlap = 1'b0;
        while (c < 40 && (r0 < 0 || r1 < 0)) begin
            tick();
            c++;
            if (mem_ready[0] && mem_ready[1]) overlap = 1'b1;
            if (mem_ready[0]) begin r0 = c; mem_read[0] = 1'b0; model_complete(0, 0, 28'd5, '0); end
            if (mem_ready[1]) begin r1 = c; mem_read[1] = 1'b0; model_complete(1, 0, 28'd7, '0); end
            if (mem_ready[1] && mem_rdata[LINE_W +: LINE_W] !== model_rdata[1]) overlap = 1'b1;
        end
        checks++; if (r0 !== TURN || r1 !== 2 * TURN + 1 || overlap) begin errors++;
            $display("FAIL contention_order: got ch0@%0d ch1@%0d ovl=%b want %0d %0d 0",
                     r0, r1, overlap, TURN, 2 * TURN + 1); end
        checks++; if (mem_rdata[0 +: LINE_W] !== model_rdata[0]) begin errors++;
            $display("FAIL contention_data0: got %h want %h", mem_rdata[0 +: LINE_W],
                     model_rdata[0]); end
        tick();
    endtask

    task automatic test_fairness();
        int c;
        int n;
        int order [4];
        int when [4];
        bit ok;
        apply_reset();
        set_req(0, 1'b1, 1'b0, 28'd7, '0);
        set_req(1, 1'b1, 1'b0, 28'd5, '0);
        c = 0; n = 0;
        while (c < 80 && n < 4) begin
            tick();
            c++;
            for (int k = 0; k < NCH; k++) begin
                if (mem_ready[k] && n < 4) begin
                    order[n] = k;
                    when[n] = c;
                    n++;
                    model_complete(k, 0, (k == 0) ? 28'd7 : 28'd5, '0);
                end
            end
        end
        mem_read = '0;
        ok = (n == 4);
        for (int i = 0; i < 4; i++) begin
            if (i < n && order[i] != i % 2) ok = 1'b0;
            if (i > 0 && i < n && when[i] - when[i-1] != TURN + 1) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++;
            $display("FAIL rr_fairness: got %0d grants order %0d%0d%0d%0d want 0101 spaced %0d",
                     n, order[0], order[1], order[2], order[3], TURN + 1); end
        checks++; if (mem_rdata !== {model_rdata[1], model_rdata[0]}) begin errors++;
            $display("FAIL rr_data: got %h want %h", mem_rdata, {model_rdata[1], model_rdata[0]});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit oth;
        bit seen;
        int k;
        for (int v = 0; v < 2; v++) begin
            k = (v == 0) ? 4 : LATENCY;
            run_txn(0, 1'b0, 1'b1, 28'd3, 128'hAA, cyc, oth);
            tick();
            set_req(0, 1'b0, 1'b1, 28'd3, {$urandom, $urandom, $urandom, $urandom});
            seen = 1'b0;
            repeat (k) begin
                tick();
                if (mem_ready !== '0) seen = 1'b1;
            end
            rst = 1'b1;
            mem_write = '0;
            tick();
            rst = 1'b0;
            for (int j = 0; j < NCH; j++) begin model_rdata[j] = '0; model_access[j] = 0; end
            checks++; if (busy !== 1'b0 || stat_busy_cycles !== '0 || stat_access !== '0) begin
                errors++;
                $display("FAIL rst_mid_state_%0d: got busy=%b stats=%0d/%h want 0", k, busy,
                         stat_busy_cycles, stat_access); end
            repeat (TURN + 3) begin
                tick();
                if (mem_ready !== '0) seen = 1'b1;
            end
            checks++; if (seen) begin errors++;
                $display("FAIL rst_mid_ready_%0d: got pulse want none", k); end
            run_txn(0, 1'b1, 1'b0, 28'd3, '0, cyc, oth);
            checks++; if (mem_rdata[0 +: LINE_W] !== 128'hAA) begin errors++;
                $display("FAIL rst_mid_data_%0d: got %h want aa", k, mem_rdata[0 +: LINE_W]); end
            tick();
        end
    endtask

    task automatic test_random();
        int cyc;
        bit oth;
        int ch;
        int op;
        int idx;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        bit ok;
        ok = 1'b1;
        for (int t = 0; t < 24; t++) begin
            ch = int'($urandom_range(0, NCH - 1));
            op = int'($urandom_range(0, 2));
            idx = 100 + int'($urandom_range(0, 5));
            // Random upper bits exercise aliasing onto the same line.
            a = ADDR_W'(($urandom << 10) | 32'(idx));
            d = {$urandom, $urandom, $urandom, $urandom};
            if (op == 0 && !model_mem.exists(idx)) op = 1;
            run_txn(ch, op != 1, op != 0, a, d, cyc, oth);
            if (cyc !== TURN || oth) ok = 1'b0;
            checks++; if (mem_rdata !== {model_rdata[1], model_rdata[0]}) begin errors++;
                $display("FAIL random_data_%0d: got %h want %h", t, mem_rdata,
                         {model_rdata[1], model_rdata[0]}); end
            tick();
        end
        checks++; if (!ok) begin errors++;
            $display("FAIL random_timing: got off-time or foreign ready want %0d cycles", TURN); end
        checks++; if (stat_busy_cycles !== exp_stat(model_busy)) begin errors++;
            $display("FAIL random_busy_stat: got %0d want %0d", stat_busy_cycles,
                     exp_stat(model_busy)); end
        checks++; if (stat_access !== {exp_stat(model_access[1]), exp_stat(model_access[0])}) begin
            errors++;
            $display("FAIL random_access_stat: got %h want %0d/%0d", stat_access,
                     exp_stat(model_access[1]), exp_stat(model_access[0])); end
    endtask

    task automatic test_stats();
        int cyc;
        bit oth;
        apply_reset();
        run_txn(0, 1'b1, 1'b0, 28'd5, '0, cyc, oth); tick();
        run_txn(1, 1'b0, 1'b1, 28'd20, 128'h55, cyc, oth); tick();
        run_txn(0, 1'b1, 1'b0, 28'd7, '0, cyc, oth); tick();
        run_txn(1, 1'b0, 1'b1, 28'd21, 128'h66, cyc, oth); tick();
        run_txn(0, 1'b1, 1'b0, 28'd3, '0, cyc, oth); tick();
        checks++; if (stat_access !== {exp_stat(2), exp_stat(3)}) begin errors++;
            $display("FAIL stats_access: got %h want %0d/%0d", stat_access, exp_stat(2),
                     exp_stat(3)); end
        checks++; if (stat_busy_cycles !== exp_stat(5 * TURN)) begin errors++;
            $display("FAIL stats_busy: got %0d want %0d", stat_busy_cycles,
                     exp_stat(5 * TURN)); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_fairness();
        test_reset_mid();
        test_random();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
